// File: rtl/logistic_pdm_snd.sv
// Logistic-map sound generator: x <- r*x*(1-x) retunes N_OSC square-wave
// oscillators round-robin; the oscillator sum leaves through a first-order PDM.

module logistic_pdm_osc #(
    parameter int PHASE_BITS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  load,
    input  logic [PHASE_BITS-1:0] load_inc,
    output logic                  osc
);
    logic [PHASE_BITS-1:0] inc;
    logic [PHASE_BITS-1:0] phase;

    // A retune lands even while paused; only the phase walk obeys en.
    always_ff @(posedge clk) begin
        if (reset) begin
            inc   <= '0;
            phase <= '0;
        end else begin
            if (load) inc <= load_inc;
            if (en) phase <= phase + inc;
        end
    end

    assign osc = phase[PHASE_BITS-1];
endmodule

module logistic_pdm_snd #(
    parameter int N_OSC      = 8,
    parameter int ITER_LEN   = 15361,
    parameter int R_INC      = 2,
    parameter int FRAC       = 16,
    parameter int PHASE_BITS = 16,
    parameter int FREQ_RES   = 0,
    parameter int R_MIN_INT  = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       r_mode,
    output logic                       snd,
    output logic [$clog2(N_OSC+1)-1:0] mix,
    output logic [FRAC-1:0]            x_out,
    output logic [FRAC+1:0]            r_out,
    output logic                       iter_strobe
);
    localparam int MIX_W  = $clog2(N_OSC+1);
    localparam int CNT_W  = $clog2(ITER_LEN);
    localparam int SLOT_W = $clog2(N_OSC);
    localparam int ACC_W  = $clog2(N_OSC);
    localparam int SUM_W  = MIX_W + 1;
    localparam int RW     = FRAC + 2;
    localparam int RW3    = FRAC + 3;
    localparam int PW     = 2*FRAC + 2;

    localparam logic [1:0]      RMI    = R_MIN_INT[1:0];
    localparam logic [FRAC:0]   ONE    = {1'b1, {FRAC{1'b0}}};
    localparam logic [RW-1:0]   R_MIN  = {RMI, {FRAC{1'b0}}};
    localparam logic [RW3-1:0]  FOUR   = {3'b100, {FRAC{1'b0}}};
    localparam logic [RW3-1:0]  R_STEP = RW3'(R_INC);
    localparam logic [RW-1:0]   Y_TOP  = {2'b01, {FRAC{1'b0}}};

    logic [CNT_W-1:0]  cnt;
    logic              tick;
    logic [1:0]        vld_pipe;
    logic [FRAC-1:0]   x, p, p_nxt, y;
    logic [FRAC:0]     one_m_x;
    logic [PW-1:0]     xp, rp;
    logic [RW-1:0]     y_raw;
    logic [RW-1:0]     r, r_nxt;
    logic [RW3-1:0]    r_up, r_dn;
    logic              dir_up, dir_nxt;
    logic [SLOT_W-1:0] slot;
    logic              last_slot;
    logic [PHASE_BITS-1:0] inc_new;
    logic [N_OSC-1:0]  osc;
    logic [MIX_W-1:0]  pop;
    logic [ACC_W-1:0]  acc;
    logic [SUM_W-1:0]  s;

    assign tick = en && (cnt == CNT_W'(ITER_LEN-1));

    always_ff @(posedge clk) begin
        if (reset) cnt <= '0;
        else if (en) cnt <= (cnt == CNT_W'(ITER_LEN-1)) ? '0 : cnt + 1'b1;
    end

    // Stage 1: p = x*(1-x); stage 2: y = r*p with saturation and a floor of 1.
    assign one_m_x = ONE - {1'b0, x};
    assign xp      = PW'(x) * PW'(one_m_x);
    assign p_nxt   = FRAC'(xp >> FRAC);
    assign rp      = PW'(r) * PW'(p);
    assign y_raw   = RW'(rp >> FRAC);

    always_comb begin
        y = y_raw[FRAC-1:0];
        if (y_raw >= Y_TOP)  y = '1;
        else if (y_raw == '0) y = FRAC'(1);
    end

    assign inc_new   = PHASE_BITS'((y >> (FRAC-PHASE_BITS)) >> FREQ_RES);
    assign last_slot = (slot == SLOT_W'(N_OSC-1));
    assign r_up      = RW3'(r) + R_STEP;
    assign r_dn      = RW3'(r) - R_STEP;

    always_comb begin
        r_nxt   = r;
        dir_nxt = dir_up;
        if (!r_mode) begin
            r_nxt = (r_up >= FOUR) ? R_MIN : RW'(r_up);
        end else if (dir_up) begin
            if (r_up >= FOUR) begin
                r_nxt   = '1;
                dir_nxt = 1'b0;
            end else begin
                r_nxt = RW'(r_up);
            end
        end else begin
            if (RW3'(r) <= RW3'(R_MIN) + R_STEP) begin
                r_nxt   = R_MIN;
                dir_nxt = 1'b1;
            end else begin
                r_nxt = RW'(r_dn);
            end
        end
    end

    // In-flight stages finish regardless of en; reset drops them.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
            p        <= '0;
            x        <= {1'b1, {(FRAC-1){1'b0}}};
            r        <= R_MIN;
            dir_up   <= 1'b1;
            slot     <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], tick};
            if (tick) p <= p_nxt;
            if (vld_pipe[0]) begin
                x    <= y;
                slot <= last_slot ? '0 : slot + 1'b1;
                if (last_slot) begin
                    r      <= r_nxt;
                    dir_up <= dir_nxt;
                end
            end
        end
    end

    for (genvar i = 0; i < N_OSC; i++) begin : g_lane
        logistic_pdm_osc #(.PHASE_BITS(PHASE_BITS)) u_osc (
            .clk      (clk),
            .reset    (reset),
            .en       (en),
            .load     (vld_pipe[0] && (slot == SLOT_W'(i))),
            .load_inc (inc_new),
            .osc      (osc[i])
        );
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < N_OSC; i++) pop = pop + MIX_W'(osc[i]);
    end

    // First-order error feedback: the residue stays below N_OSC, so density is exact.
    assign s = SUM_W'(acc) + SUM_W'(mix);

    always_ff @(posedge clk) begin
        if (reset) begin
            mix <= '0;
            acc <= '0;
            snd <= 1'b0;
        end else begin
            mix <= pop;
            if (s >= SUM_W'(N_OSC)) begin
                snd <= 1'b1;
                acc <= ACC_W'(s - SUM_W'(N_OSC));
            end else begin
                snd <= 1'b0;
                acc <= ACC_W'(s);
            end
        end
    end

    assign x_out       = x;
    assign r_out       = r;
    assign iter_strobe = vld_pipe[1];
endmodule

// File: tb/tb_logistic_pdm_snd.sv
// Directed bench: dut_a (8 oscillators) and dut_b (2 oscillators, large r step)
// share stimulus; both use ITER_LEN=4 so iterations come every 4 cycles.

module tb_logistic_pdm_snd;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b1;
    logic r_mode = 1'b0;

    logic        snd_a, stb_a, snd_b, stb_b;
    logic [3:0]  mix_a;
    logic [1:0]  mix_b;
    logic [15:0] x_a, x_b;
    logic [17:0] r_a, r_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    logistic_pdm_snd #(.ITER_LEN(4)) dut_a (
        .clk(clk), .reset(reset), .en(en), .r_mode(r_mode),
        .snd(snd_a), .mix(mix_a), .x_out(x_a), .r_out(r_a), .iter_strobe(stb_a)
    );

    logistic_pdm_snd #(.N_OSC(2), .ITER_LEN(4), .R_INC(65536), .R_MIN_INT(3)) dut_b (
        .clk(clk), .reset(reset), .en(en), .r_mode(r_mode),
        .snd(snd_b), .mix(mix_b), .x_out(x_b), .r_out(r_b), .iter_strobe(stb_b)
    );

    // Leaves the bench at the negedge of cycle 0 (first cycle with reset low).
    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        en = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        repeat (5) begin
            @(negedge clk);
            n_vec++;
            if ({snd_a, mix_a, x_a, r_a, stb_a} !== {1'b0, 4'd0, 16'd32768, 18'd196608, 1'b0}) begin
                n_err++;
                $display("FAIL reset_a: got snd=%0d mix=%0d x=%0d r=%0d stb=%0d want 0 0 32768 196608 0",
                         snd_a, mix_a, x_a, r_a, stb_a);
            end
            n_vec++;
            if ({snd_b, mix_b, x_b, r_b, stb_b} !== {1'b0, 2'd0, 16'd32768, 18'd196608, 1'b0}) begin
                n_err++;
                $display("FAIL reset_b: got snd=%0d mix=%0d x=%0d r=%0d stb=%0d want 0 0 32768 196608 0",
                         snd_b, mix_b, x_b, r_b, stb_b);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_first_iter();
        int mix_tab [13] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2, 1, 1};
        int ex;
        logic es;
        r_mode = 1'b0;
        apply_reset();
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            es = (c == 5) || (c == 9) || (c == 13);
            ex = (c < 5) ? 32768 : (c < 9) ? 49152 : (c < 13) ? 36864 : 48384;
            n_vec++;
            if (stb_a !== es || stb_b !== es) begin
                n_err++;
                $display("FAIL strobe c%0d: got a=%0d b=%0d want %0d", c, stb_a, stb_b, es);
            end
            n_vec++;
            if (x_a !== 16'(ex) || x_b !== 16'(ex)) begin
                n_err++;
                $display("FAIL x c%0d: got a=%0d b=%0d want %0d", c, x_a, x_b, ex);
            end
            n_vec++;
            if (mix_a !== 4'(mix_tab[c-1])) begin
                n_err++;
                $display("FAIL mix c%0d: got %0d want %0d", c, mix_a, mix_tab[c-1]);
            end
        end
    endtask

    task automatic test_abort();
        apply_reset();
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) @(negedge clk);
            n_vec++;
            if (stb_a !== (c == 5) || (c < 5 && x_a !== 16'd32768)) begin
                n_err++;
                $display("FAIL abort c%0d: got stb=%0d x=%0d want stb=%0d x=32768", c, stb_a, x_a, c == 5);
            end
        end
    endtask

    task automatic test_wrap();
        int k = 0;
        r_mode = 1'b0;
        apply_reset();
        for (int c = 1; c <= 40 && k < 8; c++) begin
            @(negedge clk);
            if (stb_a) begin
                k++;
                n_vec++;
                if (r_a !== ((k == 8) ? 18'd196610 : 18'd196608)) begin
                    n_err++;
                    $display("FAIL wrap_r_a s%0d: got %0d want %0d", k, r_a, (k == 8) ? 196610 : 196608);
                end
                n_vec++;
                if (r_b !== 18'd196608) begin
                    n_err++;
                    $display("FAIL wrap_r_b s%0d: got %0d want 196608", k, r_b);
                end
            end
        end
        n_vec++;
        if (k != 8) begin
            n_err++;
            $display("FAIL wrap_count: got %0d strobes want 8", k);
        end
    endtask

    task automatic test_pingpong();
        int r_tab [6] = '{196608, 262143, 262143, 196608, 196608, 262143};
        int x_tab [6] = '{49152, 36864, 64511, 4031, -1, -1};
        int k = 0;
        r_mode = 1'b1;
        apply_reset();
        for (int c = 1; c <= 40 && k < 6; c++) begin
            @(negedge clk);
            if (stb_b) begin
                n_vec++;
                if (r_b !== 18'(r_tab[k])) begin
                    n_err++;
                    $display("FAIL pingpong_r s%0d: got %0d want %0d", k + 1, r_b, r_tab[k]);
                end
                if (x_tab[k] >= 0) begin
                    n_vec++;
                    if (x_b !== 16'(x_tab[k])) begin
                        n_err++;
                        $display("FAIL pingpong_x s%0d: got %0d want %0d", k + 1, x_b, x_tab[k]);
                    end
                end
                k++;
            end
        end
        n_vec++;
        if (k != 6) begin
            n_err++;
            $display("FAIL pingpong_count: got %0d strobes want 6", k);
        end
        r_mode = 1'b0;
    endtask

    task automatic test_enable();
        int gap = -1;
        r_mode = 1'b0;
        apply_reset();
        for (int c = 1; c <= 20 && !stb_a; c++) @(negedge clk);
        n_vec++;
        if (!stb_a) begin
            n_err++;
            $display("FAIL enable_first: no strobe within bound");
        end
        repeat (3) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        n_vec++;
        if (stb_a !== 1'b1 || x_a !== 16'd36864) begin
            n_err++;
            $display("FAIL enable_inflight: got stb=%0d x=%0d want 1 36864", stb_a, x_a);
        end
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 9) en = 1'b1;
            if (c <= 10) begin
                n_vec++;
                if (mix_a !== 4'd0) begin
                    n_err++;
                    $display("FAIL enable_freeze c%0d: got mix=%0d want 0", c, mix_a);
                end
            end
            if (stb_a) begin
                gap = c;
                break;
            end
        end
        n_vec++;
        if (gap != 14 || x_a !== 16'd48384) begin
            n_err++;
            $display("FAIL enable_gap: got gap=%0d x=%0d want 14 48384", gap, x_a);
        end
        en = 1'b1;
    endtask

    task automatic test_pdm();
        int acc_a = 0, acc_b = 0;
        logic exp_a = 1'b0, exp_b = 1'b0;
        int s;
        apply_reset();
        for (int c = 0; c < 80; c++) begin
            if (c > 0) @(negedge clk);
            n_vec++;
            if (snd_a !== exp_a) begin
                n_err++;
                $display("FAIL pdm_a c%0d: got %0d want %0d", c, snd_a, exp_a);
            end
            n_vec++;
            if (snd_b !== exp_b) begin
                n_err++;
                $display("FAIL pdm_b c%0d: got %0d want %0d", c, snd_b, exp_b);
            end
            s = acc_a + int'(mix_a);
            exp_a = (s >= 8);
            acc_a = exp_a ? s - 8 : s;
            s = acc_b + int'(mix_b);
            exp_b = (s >= 2);
            acc_b = exp_b ? s - 2 : s;
        end
    endtask

    initial begin
        test_reset();
        test_first_iter();
        test_abort();
        test_wrap();
        test_pingpong();
        test_enable();
        test_pdm();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/logistic_pdm_snd.md
Name: logistic_pdm_snd

Overview:
- Next-generation logistic-map sound generator.
- A fixed-point logistic map x <- r*x*(1-x) is iterated once every ITER_LEN clocks. Each new x value retunes one of N_OSC square-wave oscillators in round-robin order. r sweeps in either wrap or ping-pong mode.
- The oscillator outputs are summed and driven out through an exact first-order PDM modulator to a single pin.
- Adds an enable input, a selectable sweep mode, saturation, and debug/strobe outputs.

Parameters:
- N_OSC, 8: number of oscillators; must be >= 2.
- ITER_LEN, 15361: clocks per logistic iteration; must be >= 3.
- R_INC, 2: r step size, in LSBs, applied per full round-robin pass.
- FRAC, 16: fraction bits of x and r.
- PHASE_BITS, 16: phase accumulator width; must be <= FRAC.
- FREQ_RES, 0: extra right shift applied to increments.
- R_MIN_INT, 3: lower bound of r, equal to R_MIN_INT<<FRAC; must be 0..3.

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high reset.
- en, in, 1: run enable.
- r_mode, in, 1: 0 = wrap sweep, 1 = ping-pong sweep.
- snd, out, 1: PDM audio output.
- mix, out, clog2(N_OSC+1): count of oscillators currently high.
- x_out, out, FRAC: current x.
- r_out, out, FRAC+2: current r.
- iter_strobe, out, 1: one-cycle pulse when a new x becomes visible.

Behaviour:
- Reset (synchronous, active-high; priority over en):
  - x = 1<<(FRAC-1), i.e. 0.5.
  - r = R_MIN_INT<<FRAC; direction = up.
  - Tick counter, slot, all phases and increments, PDM accumulator = 0.
  - snd = 0, mix = 0, iter_strobe = 0.
- Tick counter:
  - Counts 0..ITER_LEN-1 while en=1, then wraps to 0.
  - A tick is the cycle where count == ITER_LEN-1 and en=1.
- Iteration pipeline:
  - Tick cycle T: register p = (x*((1<<FRAC)-x))>>FRAC.
  - Cycle T+1: compute y = (r*p)>>FRAC.
  - Saturate y to (1<<FRAC)-1. If y == 0, force y = 1 so x never sticks at 0.
  - x, inc[slot] and iter_strobe become visible in cycle T+2.
  - inc[slot] = (y >> (FRAC-PHASE_BITS)) >> FREQ_RES.
  - Slot advances modulo N_OSC in the same cycle.
- r update: when slot wraps from N_OSC-1 to 0, r updates in the same cycle x becomes visible.
  - Mode 0: r += R_INC. If the result is >= 4<<FRAC, r reloads to R_MIN_INT<<FRAC.
  - Mode 1, going up: if r+R_INC >= 4<<FRAC, set r = (4<<FRAC)-1 and direction = down.
  - Mode 1, going down: if r-R_INC <= R_MIN_INT<<FRAC, set r = R_MIN_INT<<FRAC and direction = up.
  - A change on r_mode takes effect at the next r update; direction is kept across mode changes.
- Oscillators: while en=1, phase[i] += inc[i] modulo 2^PHASE_BITS each cycle. osc[i] = phase[i] MSB.
- mix is the registered popcount of osc, one cycle behind the phases.
- PDM (runs every cycle, regardless of en):
  - s = acc + mix.
  - If s >= N_OSC: snd = 1 and acc = s-N_OSC.
  - Otherwise: snd = 0 and acc = s.
  - Long-run density of snd is exactly mix/N_OSC.
- en = 0:
  - Tick counter, phases, x, r and slot all hold.
  - An iteration already in flight (T+1/T+2) completes.
  - PDM keeps running on the held mix.
- Reset mid-iteration aborts the pipeline: no strobe and no x write occur.

Test Plan:
- Reset → snd=0, mix=0, x_out=32768, r_out=196608, iter_strobe=0. Hold reset for 5 cycles with en=1 and confirm nothing changes.
- ITER_LEN=4, defaults, en=1:
  - First iter_strobe occurs at cycle 5 after reset release.
  - x_out=49152; inc[0]=49152.
  - Next strobe 4 cycles later with x_out=36864.
- N_OSC=2, force mix to 2 / 0 / 1 via chosen increments → snd constant 1 / constant 0 / alternating 1,0 with density exactly 1/2.
- Mode 0 with R_INC=65536 and R_MIN_INT=3 → r goes 196608, 262143-range wrap back to 196608 after one full slot pass. Saturation case: r near 4 with x=0.5 → x_out=65535.
- Mode 1 ping-pong → r rises to 262143, then steps down by R_INC, then clamps at 196608 and rises again. The strobe count between reversals equals N_OSC times the number of steps.
- en dropped for 10 cycles at the tick cycle → the in-flight strobe still occurs, then the phases and counter freeze, and the next strobe is delayed by exactly 10 cycles.
